// File: rtl/counter_bus_arb.sv
// Two-master round-robin arbiter/sequencer for the counter_if register bus.
// Optional BUSY abort timer enabled by defining COUNTER_ARB_TIMEOUT_EN.
module counter_bus_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst,
  input  logic        i_m0_select,
  input  logic        i_m0_wr,
  input  logic [3:0]  i_m0_addr,
  input  logic [15:0] i_m0_data,
  input  logic        i_m1_select,
  input  logic        i_m1_wr,
  input  logic [3:0]  i_m1_addr,
  input  logic [15:0] i_m1_data,
  output logic [15:0] o_m0_data,
  output logic [15:0] o_m1_data,
  output logic        o_m0_ack,
  output logic        o_m1_ack,
  output logic        o_bus_select,
  output logic        o_bus_wr,
  output logic [3:0]  o_reg_addr,
  output logic [15:0] o_bus_data,
  input  logic [15:0] i_bus_data,
  input  logic        i_bus_ack,
  output logic        o_timeout_flg
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  logic   last;
  logic   gnt;
  logic   req;
  logic   pick;
  logic   gnt_sel;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("counter_bus_arb: TIMEOUT must be in 1..255");
  end

  // A tie goes to the master that was not granted last.
  always_comb begin
    req     = (i_m0_select | i_m1_select) & ~i_bus_ack;
    pick    = (i_m0_select & i_m1_select) ? ~last : i_m1_select;
    gnt_sel = gnt ? i_m1_select : i_m0_select;
  end

`ifdef COUNTER_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_hit;
  // Abort lands on the TIMEOUT-th BUSY edge without ack.
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));
`else
  assign o_timeout_flg = 1'b0;
`endif

  always_ff @(posedge i_sysclk or negedge i_sysrst) begin
    if (!i_sysrst) begin
      state        <= IDLE;
      last         <= 1'b1;
      gnt          <= 1'b0;
      o_m0_data    <= '0;
      o_m1_data    <= '0;
      o_m0_ack     <= 1'b0;
      o_m1_ack     <= 1'b0;
      o_bus_select <= 1'b0;
      o_bus_wr     <= 1'b0;
      o_reg_addr   <= '0;
      o_bus_data   <= '0;
`ifdef COUNTER_ARB_TIMEOUT_EN
      tmo_cnt       <= '0;
      o_timeout_flg <= 1'b0;
`endif
    end else begin
`ifdef COUNTER_ARB_TIMEOUT_EN
      o_timeout_flg <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            gnt          <= pick;
            last         <= pick;
            o_bus_select <= 1'b1;
            o_bus_wr     <= pick ? i_m1_wr   : i_m0_wr;
            o_reg_addr   <= pick ? i_m1_addr : i_m0_addr;
            o_bus_data   <= pick ? i_m1_data : i_m0_data;
            state        <= BUSY;
`ifdef COUNTER_ARB_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
          end
        end
        BUSY: begin
          if (i_bus_ack) begin
            if (gnt) begin
              o_m1_data <= i_bus_data;
              o_m1_ack  <= 1'b1;
            end else begin
              o_m0_data <= i_bus_data;
              o_m0_ack  <= 1'b1;
            end
            o_bus_select <= 1'b0;
            o_bus_wr     <= 1'b0;
            state        <= DONE;
          end
`ifdef COUNTER_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            if (gnt) begin
              o_m1_data <= '1;
              o_m1_ack  <= 1'b1;
            end else begin
              o_m0_data <= '1;
              o_m0_ack  <= 1'b1;
            end
            o_bus_select  <= 1'b0;
            o_bus_wr      <= 1'b0;
            o_timeout_flg <= 1'b1;
            state         <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          if (!gnt_sel) begin
            if (gnt) o_m1_ack <= 1'b0;
            else     o_m0_ack <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_bus_arb.sv
// Directed, table-driven self-checking bench for counter_bus_arb.
module tb_counter_bus_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_sel, m0_wr, m1_sel, m1_wr;
  logic [3:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic [15:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        bus_sel, bus_wr;
  logic [3:0]  reg_addr;
  logic [15:0] bus_wdata, bus_rdata;
  logic        bus_ack;
  logic        tmo_flg;

  always #5 clk = ~clk;

  counter_bus_arb #(.TIMEOUT(8)) dut (
    .i_sysclk(clk), .i_sysrst(rst_n),
    .i_m0_select(m0_sel), .i_m0_wr(m0_wr), .i_m0_addr(m0_addr), .i_m0_data(m0_wdata),
    .i_m1_select(m1_sel), .i_m1_wr(m1_wr), .i_m1_addr(m1_addr), .i_m1_data(m1_wdata),
    .o_m0_data(m0_rdata), .o_m1_data(m1_rdata), .o_m0_ack(m0_ack), .o_m1_ack(m1_ack),
    .o_bus_select(bus_sel), .o_bus_wr(bus_wr), .o_reg_addr(reg_addr), .o_bus_data(bus_wdata),
    .i_bus_data(bus_rdata), .i_bus_ack(bus_ack), .o_timeout_flg(tmo_flg)
  );

  typedef struct packed {
    logic bs; logic bw; logic [3:0] a; logic [15:0] bd;
    logic a0; logic [15:0] d0; logic a1; logic [15:0] d1; logic f;
  } outs_t;

  typedef struct packed {
    logic s0; logic w0; logic [3:0] a0; logic [15:0] d0;
    logic s1; logic w1; logic [3:0] a1; logic [15:0] d1;
    logic ack; logic [15:0] rd;
  } ins_t;

  typedef struct { ins_t in; outs_t exp; } vec_t;

  vec_t vecs[18];
  int total = 0;
  int bad   = 0;

  function automatic outs_t o(input logic bs, input logic bw, input logic [3:0] a,
                              input logic [15:0] bd, input logic a0, input logic [15:0] d0,
                              input logic a1, input logic [15:0] d1, input logic f = 1'b0);
    outs_t r;
    r.bs = bs; r.bw = bw; r.a = a; r.bd = bd;
    r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1; r.f = f;
    return r;
  endfunction

  function automatic ins_t i(input logic s0, input logic w0, input logic [3:0] a0,
                             input logic [15:0] d0, input logic s1, input logic w1,
                             input logic [3:0] a1, input logic [15:0] d1,
                             input logic ack, input logic [15:0] rd);
    ins_t r;
    r.s0 = s0; r.w0 = w0; r.a0 = a0; r.d0 = d0;
    r.s1 = s1; r.w1 = w1; r.a1 = a1; r.d1 = d1;
    r.ack = ack; r.rd = rd;
    return r;
  endfunction

  task automatic drive(input ins_t v);
    m0_sel = v.s0; m0_wr = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_sel = v.s1; m1_wr = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    bus_ack = v.ack; bus_rdata = v.rd;
  endtask

  task automatic check(input string name, input outs_t exp);
    outs_t act;
    act = o(bus_sel, bus_wr, reg_addr, bus_wdata, m0_ack, m0_rdata, m1_ack, m1_rdata, tmo_flg);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
  task automatic cyc(input ins_t v, input string name, input outs_t exp);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("reset_state", o(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned n0, n1;
    logic [15:0] e0, e1;
    logic        g;

    // m0 write (addr/data wiggled after grant), m1 read, stray m0 request in DONE,
    // then slave ack held high across IDLE.
    vecs[0]  = '{i(1,1,4'h1,16'h0F01, 0,0,0,0, 0,0),          o(1,1,4'h1,16'h0F01, 0,16'h0000, 0,16'h0000)};
    vecs[1]  = '{i(1,1,4'hF,16'hFFFF, 0,0,0,0, 0,0),          o(1,1,4'h1,16'h0F01, 0,16'h0000, 0,16'h0000)};
    vecs[2]  = '{i(1,1,4'hF,16'hFFFF, 0,0,0,0, 0,0),          o(1,1,4'h1,16'h0F01, 0,16'h0000, 0,16'h0000)};
    vecs[3]  = '{i(1,1,4'h1,16'h0F01, 0,0,0,0, 1,16'h5A5A),   o(0,0,4'h1,16'h0F01, 1,16'h5A5A, 0,16'h0000)};
    vecs[4]  = '{i(1,1,4'h1,16'h0F01, 0,0,0,0, 0,0),          o(0,0,4'h1,16'h0F01, 1,16'h5A5A, 0,16'h0000)};
    vecs[5]  = '{i(0,0,0,0, 0,0,0,0, 0,0),                    o(0,0,4'h1,16'h0F01, 0,16'h5A5A, 0,16'h0000)};
    vecs[6]  = '{i(0,0,0,0, 1,0,4'h2,16'h7777, 0,0),          o(1,0,4'h2,16'h7777, 0,16'h5A5A, 0,16'h0000)};
    vecs[7]  = '{i(0,0,0,0, 1,0,4'h2,16'h7777, 1,16'h1234),   o(0,0,4'h2,16'h7777, 0,16'h5A5A, 1,16'h1234)};
    vecs[8]  = '{i(1,1,4'h9,16'h9999, 1,0,4'h2,16'h7777, 0,0),o(0,0,4'h2,16'h7777, 0,16'h5A5A, 1,16'h1234)};
    vecs[9]  = '{i(1,0,4'h3,16'h0003, 0,0,0,0, 0,0),          o(0,0,4'h2,16'h7777, 0,16'h5A5A, 0,16'h1234)};
    vecs[10] = '{i(1,0,4'h3,16'h0003, 0,0,0,0, 0,0),          o(1,0,4'h3,16'h0003, 0,16'h5A5A, 0,16'h1234)};
    vecs[11] = '{i(1,0,4'h3,16'h0003, 0,0,0,0, 1,16'hBEEF),   o(0,0,4'h3,16'h0003, 1,16'hBEEF, 0,16'h1234)};
    vecs[12] = '{i(0,0,0,0, 0,0,0,0, 1,16'hBEEF),             o(0,0,4'h3,16'h0003, 0,16'hBEEF, 0,16'h1234)};
    vecs[13] = '{i(0,0,0,0, 1,1,4'h4,16'h4444, 1,16'hBEEF),   o(0,0,4'h3,16'h0003, 0,16'hBEEF, 0,16'h1234)};
    vecs[14] = '{i(0,0,0,0, 1,1,4'h4,16'h4444, 1,16'hBEEF),   o(0,0,4'h3,16'h0003, 0,16'hBEEF, 0,16'h1234)};
    vecs[15] = '{i(0,0,0,0, 1,1,4'h4,16'h4444, 0,0),          o(1,1,4'h4,16'h4444, 0,16'hBEEF, 0,16'h1234)};
    vecs[16] = '{i(0,0,0,0, 1,1,4'h4,16'h4444, 1,16'h0044),   o(0,0,4'h4,16'h4444, 0,16'hBEEF, 1,16'h0044)};
    vecs[17] = '{i(0,0,0,0, 0,0,0,0, 0,0),                    o(0,0,4'h4,16'h4444, 0,16'hBEEF, 0,16'h0044)};

    rst_n = 1'b0;
    drive(i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_reset();

    for (int k = 0; k < 18; k++)
      cyc(vecs[k].in, $sformatf("vec%0d", k), vecs[k].exp);

    // Competing requests from reset: strict alternation starting with m0.
    do_reset();
    n0 = 0; n1 = 0; e0 = '0; e1 = '0;
    for (int k = 0; k < 6; k++) begin
      g = k[0];
      @(negedge clk);
      drive(i(1, 1, 4'(n0), 16'hA000 + 16'(n0), 1, 0, 4'(8 + n1), 16'hB000 + 16'(n1), 0, 0));
      @(posedge clk); #1;
      if (!g) check($sformatf("rr_grant%0d", k), o(1, 1, 4'(n0), 16'hA000 + 16'(n0), 0, e0, 0, e1));
      else    check($sformatf("rr_grant%0d", k), o(1, 0, 4'(8 + n1), 16'hB000 + 16'(n1), 0, e0, 0, e1));
      @(negedge clk);
      bus_ack = 1'b1; bus_rdata = 16'hC000 + 16'(k);
      @(posedge clk); #1;
      if (!g) begin
        e0 = 16'hC000 + 16'(k);
        check($sformatf("rr_ack%0d", k), o(0, 0, 4'(n0), 16'hA000 + 16'(n0), 1, e0, 0, e1));
      end else begin
        e1 = 16'hC000 + 16'(k);
        check($sformatf("rr_ack%0d", k), o(0, 0, 4'(8 + n1), 16'hB000 + 16'(n1), 0, e0, 1, e1));
      end
      @(negedge clk);
      bus_ack = 1'b0;
      if (!g) m0_sel = 1'b0; else m1_sel = 1'b0;
      @(posedge clk); #1;
      if (!g) check($sformatf("rr_drop%0d", k), o(0, 0, 4'(n0), 16'hA000 + 16'(n0), 0, e0, 0, e1));
      else    check($sformatf("rr_drop%0d", k), o(0, 0, 4'(8 + n1), 16'hB000 + 16'(n1), 0, e0, 0, e1));
      if (!g) n0++; else n1++;
    end

    // Asynchronous reset in the middle of a BUSY cycle.
    cyc(i(1, 1, 4'h5, 16'h5555, 0, 0, 0, 0, 0, 0), "rst_pre_busy", o(1, 1, 4'h5, 16'h5555, 0, e0, 0, e1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", o(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(i(1, 0, 4'h6, 16'h0606, 1, 1, 4'hE, 16'h0E0E, 0, 0), "rst_regrant", o(1, 0, 4'h6, 16'h0606, 0, 0, 0, 0));
    cyc(i(1, 0, 4'h6, 16'h0606, 1, 1, 4'hE, 16'h0E0E, 1, 16'h1111), "rst_ack", o(0, 0, 4'h6, 16'h0606, 1, 16'h1111, 0, 0));
    cyc(i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_drop", o(0, 0, 4'h6, 16'h0606, 0, 16'h1111, 0, 0));

`ifdef COUNTER_ARB_TIMEOUT_EN
    // Slave never acks: abort on the 8th BUSY edge with all-ones data.
    cyc(i(0, 0, 0, 0, 1, 1, 4'h6, 16'h6666, 0, 0), "tmo_grant", o(1, 1, 4'h6, 16'h6666, 0, 16'h1111, 0, 0));
    for (int k = 1; k < 8; k++)
      cyc(i(0, 0, 0, 0, 1, 1, 4'h6, 16'h6666, 0, 0), $sformatf("tmo_wait%0d", k),
          o(1, 1, 4'h6, 16'h6666, 0, 16'h1111, 0, 0));
    cyc(i(0, 0, 0, 0, 1, 1, 4'h6, 16'h6666, 0, 0), "tmo_abort", o(0, 0, 4'h6, 16'h6666, 0, 16'h1111, 1, 16'hFFFF, 1));
    cyc(i(0, 0, 0, 0, 1, 1, 4'h6, 16'h6666, 0, 0), "tmo_flg_once", o(0, 0, 4'h6, 16'h6666, 0, 16'h1111, 1, 16'hFFFF, 0));
    cyc(i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "tmo_drop", o(0, 0, 4'h6, 16'h6666, 0, 16'h1111, 0, 16'hFFFF));
`else
    // Without the timer BUSY waits indefinitely and the flag never rises.
    cyc(i(0, 0, 0, 0, 1, 1, 4'h6, 16'h6666, 0, 0), "wait_grant", o(1, 1, 4'h6, 16'h6666, 0, 16'h1111, 0, 0));
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    check("wait_still_busy", o(1, 1, 4'h6, 16'h6666, 0, 16'h1111, 0, 0));
    cyc(i(0, 0, 0, 0, 1, 1, 4'h6, 16'h6666, 1, 16'h6060), "wait_ack", o(0, 0, 4'h6, 16'h6666, 0, 16'h1111, 1, 16'h6060));
    cyc(i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wait_drop", o(0, 0, 4'h6, 16'h6666, 0, 16'h1111, 0, 16'h6060));
`endif

    // A normal transaction still completes afterwards.
    cyc(i(0, 0, 0, 0, 1, 0, 4'h7, 16'h0007, 0, 0), "post_grant", o(1, 0, 4'h7, 16'h0007, 0, 16'h1111, 0, m1_rdata));
    cyc(i(0, 0, 0, 0, 1, 0, 4'h7, 16'h0007, 1, 16'h7070), "post_ack", o(0, 0, 4'h7, 16'h0007, 0, 16'h1111, 1, 16'h7070));
    cyc(i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_drop", o(0, 0, 4'h7, 16'h0007, 0, 16'h1111, 0, 16'h7070));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
